// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, default widths and polynomials for the BIST sequencer
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } bist_state_e;

    localparam int CUT_PI_W = 35;
    localparam int CUT_PO_W = 49;

    localparam logic [CUT_PI_W-1:0] LFSR_TAPS_DEF = 35'h0_0000_0005;
    localparam logic [CUT_PO_W-1:0] MISR_TAPS_DEF = 49'h0_0000_0000_0201;
    localparam logic [CUT_PI_W-1:0] LFSR_SEED_DEF = 35'h1;

    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1
    function automatic logic [CUT_PI_W-1:0] safe_seed(input logic [CUT_PI_W-1:0] seed);
        return (seed == '0) ? CUT_PI_W'(1) : seed;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - Galois shift register used both as pattern LFSR and as output-compacting MISR
module bist_lfsr #(
    parameter int             W       = 35,
    parameter logic [W-1:0]   TAPS    = '0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         shift,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] q
);

    logic [W-1:0] reg_q;
    logic [W-1:0] reg_d;

    // Load takes priority; a shift folds the feedback taps and the parallel input into the new value
    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = seed;
        end else if (shift) begin
            reg_d = {reg_q[W-2:0], 1'b0} ^ (reg_q[W-1] ? TAPS : '0) ^ data_in;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_q <= RST_VAL;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer top; optional sig_out/pat_cnt debug ports under BIST_SIG_OUT_EN
module bist_controller
    import bist_pkg::*;
#(
    parameter int               PI_W         = CUT_PI_W,
    parameter int               PO_W         = CUT_PO_W,
    parameter int               NUM_PATTERNS = 2000,
    parameter int               INIT_CYCLES  = 4,
    parameter logic [PI_W-1:0]  LFSR_SEED    = LFSR_SEED_DEF,
    parameter logic [PI_W-1:0]  LFSR_TAPS    = LFSR_TAPS_DEF,
    parameter logic [PO_W-1:0]  MISR_TAPS    = MISR_TAPS_DEF,
    parameter logic [PO_W-1:0]  GOLDEN_SIG   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
    output logic            cut_rst,
    output logic            bistdone,
    output logic            bistpass
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [PO_W-1:0] sig_out,
    output logic [19:0]     pat_cnt
`endif
);

    localparam int              PAT_W     = $clog2(NUM_PATTERNS + 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [7:0]      INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [PI_W-1:0] SEED_EFF  = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

    bist_state_e      state_q, state_d;
    logic [7:0]       init_cnt_q, init_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic             pass_q, pass_d;
    logic             cut_rst_q, cut_rst_d;
    logic             bistdone_q, bistdone_d;
    logic             bistpass_q, bistpass_d;

    logic [PI_W-1:0]  lfsr_q;
    logic [PO_W-1:0]  misr_q;
    logic             seq_load;
    logic             seq_shift;

    // Both registers are reseeded throughout INIT and step once per applied pattern in RUN
    always_comb begin
        seq_load  = (state_q == INIT);
        seq_shift = (state_q == RUN);
    end

    bist_lfsr #(
        .W       (PI_W),
        .TAPS    (LFSR_TAPS),
        .RST_VAL (SEED_EFF)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (seq_load),
        .seed    (SEED_EFF),
        .shift   (seq_shift),
        .data_in ('0),
        .q       (lfsr_q)
    );

    bist_lfsr #(
        .W       (PO_W),
        .TAPS    (MISR_TAPS),
        .RST_VAL ('0)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (seq_load),
        .seed    ('0),
        .shift   (seq_shift),
        .data_in (cut_po),
        .q       (misr_q)
    );

    // Next-state and counter logic; dropping bistmode before DONE abandons the run
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        pass_d     = pass_q;
        unique case (state_q)
            IDLE: begin
                init_cnt_d = '0;
                pat_cnt_d  = '0;
                pass_d     = 1'b0;
                if (bistmode) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                if (!bistmode) begin
                    state_d = IDLE;
                end else if (init_cnt_q == INIT_LAST) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (!bistmode) begin
                    state_d = IDLE;
                end else begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    if (pat_cnt_q == PAT_LAST) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (!bistmode) begin
                    state_d = IDLE;
                end else begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bistmode) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Chip-pin outputs are decoded from the next state so they register cleanly with the FSM
    always_comb begin
        cut_rst_d  = (state_d == INIT);
        bistdone_d = (state_d == DONE);
        bistpass_d = (state_d == DONE) && pass_d;
    end

    // FSM, counters and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
            pat_cnt_q  <= '0;
            pass_q     <= 1'b0;
            cut_rst_q  <= 1'b0;
            bistdone_q <= 1'b0;
            bistpass_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            pass_q     <= pass_d;
            cut_rst_q  <= cut_rst_d;
            bistdone_q <= bistdone_d;
            bistpass_q <= bistpass_d;
        end
    end

    // CUT input mux: LFSR patterns only while RUN, system inputs otherwise
    always_comb begin
        cut_pi = (state_q == RUN) ? lfsr_q : pi;
    end

    assign cut_rst  = cut_rst_q;
    assign bistdone = bistdone_q;
    assign bistpass = bistpass_q;

`ifdef BIST_SIG_OUT_EN
    assign sig_out = misr_q;
    assign pat_cnt = 20'(pat_cnt_q);
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - self-checking bench: boundary vector table plus randomized full-length runs against a signature model
module tb_bist_controller;

    localparam logic [34:0] LFSR_T = 35'h0_0000_0005;
    localparam logic [48:0] MISR_T = 49'h0_0000_0000_0201;
    localparam logic [34:0] SEED   = 35'h1;
    localparam int NP_A = 2000;
    localparam int IC_A = 4;
    localparam int NP_B = 1;
    localparam int IC_B = 1;

    // Behavioural CUT: a fixed mixing of the 35 inputs onto 49 outputs
    function automatic logic [48:0] cut_f(input logic [34:0] x);
        return {x[13:0], x} ^ {x, x[34:21]} ^ 49'h0_0F0F_0000_00F0;
    endfunction

    function automatic logic [34:0] lstep(input logic [34:0] l);
        return {l[33:0], 1'b0} ^ (l[34] ? LFSR_T : 35'h0);
    endfunction

    // Signature after np patterns with an OR-mask stuck-at-1 applied to the CUT outputs
    function automatic logic [48:0] model_sig(input int np, input logic [48:0] fmask);
        logic [34:0] l;
        logic [48:0] m;
        int          k;
        l = SEED;
        m = 49'h0;
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 500; i++) begin
                k = o * 500 + i;
                if (k < np) begin
                    m = {m[47:0], 1'b0} ^ (m[48] ? MISR_T : 49'h0) ^ (cut_f(l) | fmask);
                    l = lstep(l);
                end
            end
        end
        return m;
    endfunction

    localparam logic [48:0] GOLD_A = model_sig(NP_A, 49'h0);
    localparam logic [48:0] GOLD_B = model_sig(NP_B, 49'h0);

    logic        clk = 1'b0;
    logic        rst;
    logic        bm_a, bm_b;
    logic [34:0] pi;
    logic [48:0] fmask;
    logic [48:0] po_a, po_b;
    logic [34:0] cpi_a, cpi_b;
    logic        crst_a, crst_b, done_a, done_b, pass_a, pass_b;
`ifdef BIST_SIG_OUT_EN
    logic [48:0] sig_a, sig_b;
    logic [19:0] pc_a, pc_b;
`endif

    assign po_a = cut_f(cpi_a) | fmask;
    assign po_b = cut_f(cpi_b);

    always #5 clk = ~clk;

    bist_controller #(.NUM_PATTERNS(NP_A), .INIT_CYCLES(IC_A), .GOLDEN_SIG(GOLD_A)) dut_a (
        .clk(clk), .rst(rst), .bistmode(bm_a), .pi(pi), .cut_po(po_a),
        .cut_pi(cpi_a), .cut_rst(crst_a), .bistdone(done_a), .bistpass(pass_a)
`ifdef BIST_SIG_OUT_EN
        , .sig_out(sig_a), .pat_cnt(pc_a)
`endif
    );

    bist_controller #(.NUM_PATTERNS(NP_B), .INIT_CYCLES(IC_B), .GOLDEN_SIG(GOLD_B)) dut_b (
        .clk(clk), .rst(rst), .bistmode(bm_b), .pi(pi), .cut_po(po_b),
        .cut_pi(cpi_b), .cut_rst(crst_b), .bistdone(done_b), .bistpass(pass_b)
`ifdef BIST_SIG_OUT_EN
        , .sig_out(sig_b), .pat_cnt(pc_b)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic rand_pi();
        logic [63:0] r;
        r  = {$urandom, $urandom};
        pi = r[34:0];
    endtask

    // One complete BIST run on dut_a from IDLE, checking every cycle against the model
    task automatic run_a(input logic [48:0] mask, input string tag, output logic got_pass);
        logic [34:0] l;
        logic [48:0] exp_sig;
        int          n;
        bit          seq_ok, rst_ok, done_seen, hold_ok;
        fmask     = mask;
        exp_sig   = model_sig(NP_A, mask);
        l         = SEED;
        seq_ok    = 1;
        rst_ok    = 1;
        hold_ok   = 1;
        done_seen = 0;
        n         = 0;
        bm_a      = 1'b1;
        while (!done_seen && n < 2100) begin
            rand_pi();
            @(posedge clk); #1;
            n++;
            if (crst_a !== ((n >= 1) && (n <= IC_A))) rst_ok = 0;
            if (n > IC_A && n <= IC_A + NP_A) begin
                if (cpi_a !== l) seq_ok = 0;
                l = lstep(l);
            end else if (cpi_a !== pi) begin
                seq_ok = 0;
            end
            if (done_a === 1'b1) done_seen = 1;
        end
        check({tag, " done_edge"}, 64'(n), 64'(2 + IC_A + NP_A));
        check({tag, " cut_rst_window"}, 64'(rst_ok), 64'd1);
        check({tag, " cut_pi_sequence"}, 64'(seq_ok), 64'd1);
        check({tag, " bistpass"}, 64'(pass_a), 64'(exp_sig == GOLD_A));
        got_pass = pass_a;
`ifdef BIST_SIG_OUT_EN
        check({tag, " sig_out"}, 64'(sig_a), 64'(exp_sig));
        check({tag, " pat_cnt"}, 64'(pc_a), 64'(NP_A));
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_a !== 1'b1 || crst_a !== 1'b0 || pass_a !== got_pass) hold_ok = 0;
        end
        check({tag, " done_hold_no_rerun"}, 64'(hold_ok), 64'd1);
        bm_a = 1'b0;
        @(posedge clk); #1;
        check({tag, " exit_done"}, {62'd0, done_a, pass_a}, 64'd0);
        fmask = 49'h0;
    endtask

    typedef struct {
        logic        bm;
        logic [34:0] pi;
        logic [34:0] cpi;
        logic        crst;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t tbl[7];
    int   exp_pass_tally, exp_fail_tally, act_pass_tally, act_fail_tally;

    initial begin
        logic        p;
        logic [48:0] m;
        int          n;

        tbl[0] = '{1'b1, 35'h1_2345_6789, 35'h1_2345_6789, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 35'h2_0F0F_0F0F, SEED,            1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 35'h7_FFFF_0000, 35'h7_FFFF_0000, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 35'h0_0000_FFFF, 35'h0_0000_FFFF, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 35'h3_3333_3333, 35'h3_3333_3333, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 35'h4_4444_4444, 35'h4_4444_4444, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 35'h5_5555_5555, 35'h5_5555_5555, 1'b0, 1'b0, 1'b0};

        exp_pass_tally = 0; exp_fail_tally = 0;
        act_pass_tally = 0; act_fail_tally = 0;

        rst = 1'b1; bm_a = 1'b0; bm_b = 1'b0; fmask = 49'h0;
        pi  = 35'h5_A5A5_A5A5;
        #2 rst = 1'b0;
        #1;
        check("reset cut_rst_a", 64'(crst_a), 64'd0);
        check("reset done_pass_a", {62'd0, done_a, pass_a}, 64'd0);
        check("reset cut_pi_a", 64'(cpi_a), 64'(pi));
        check("reset done_pass_b", {61'd0, crst_b, done_b, pass_b}, 64'd0);
`ifdef BIST_SIG_OUT_EN
        check("reset sig_out", 64'(sig_a), 64'd0);
        check("reset pat_cnt", 64'(pc_a), 64'd0);
`endif
        @(posedge clk); #3 rst = 1'b1;

        // System mode: pass-through, no BIST activity
        for (int i = 0; i < 12; i++) begin
            if (i == 0) pi = 35'h5_A5A5_A5A5; else rand_pi();
            @(posedge clk); #1;
            check("sysmode cut_pi", 64'(cpi_a), 64'(pi));
            check("sysmode done_rst", {62'd0, done_a, crst_a}, 64'd0);
        end

        // Boundary: one init cycle, one pattern
        for (int i = 0; i < 7; i++) begin
            bm_b = tbl[i].bm;
            pi   = tbl[i].pi;
            @(posedge clk); #1;
            check($sformatf("bnd[%0d] cut_pi", i), 64'(cpi_b), 64'(tbl[i].cpi));
            check($sformatf("bnd[%0d] rst_done_pass", i), {61'd0, crst_b, done_b, pass_b},
                  {61'd0, tbl[i].crst, tbl[i].done, tbl[i].pass});
`ifdef BIST_SIG_OUT_EN
            if (i == 3) begin
                check("bnd sig_out", 64'(sig_b), 64'(cut_f(SEED)));
                check("bnd pat_cnt", 64'(pc_b), 64'd1);
            end
`endif
        end

        // Fault-free run twice, then stuck-at-1 injections
        for (int r = 0; r < 5; r++) begin
            if (r < 2) m = 49'h0;
            else m = 49'h1 << $urandom_range(48, 0);
            if (model_sig(NP_A, m) == GOLD_A) exp_pass_tally++; else exp_fail_tally++;
            run_a(m, $sformatf("run%0d", r), p);
            if (p === 1'b1) act_pass_tally++; else act_fail_tally++;
        end
        check("pass_tally", 64'(act_pass_tally), 64'(exp_pass_tally));
        check("fail_tally", 64'(act_fail_tally), 64'(exp_fail_tally));
        check("fault_free_pass_count", 64'(act_pass_tally >= 2), 64'd1);

        // Abort at RUN cycle 500, then a full rerun
        bm_a = 1'b1;
        n = 0;
        while (n < IC_A + 500) begin
            rand_pi();
            @(posedge clk); #1;
            n++;
        end
        bm_a = 1'b0;
        rand_pi();
        @(posedge clk); #1;
        check("abort cut_pi", 64'(cpi_a), 64'(pi));
        check("abort rst_done_pass", {61'd0, crst_a, done_a, pass_a}, 64'd0);
        @(posedge clk); #1;
        run_a(49'h0, "after_abort", p);

        // Asynchronous reset during INIT and during RUN
        bm_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("init cut_rst high", 64'(crst_a), 64'd1);
        #2 rst = 1'b0;
        #1 check("async rst in INIT cut_rst", 64'(crst_a), 64'd0);
        bm_a = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        bm_a = 1'b1;
        repeat (1000) @(posedge clk);
        rand_pi();
        #3 rst = 1'b0;
        #1;
        check("async rst in RUN cut_pi", 64'(cpi_a), 64'(pi));
        check("async rst in RUN rst_done_pass", {61'd0, crst_a, done_a, pass_a}, 64'd0);
        bm_a = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        run_a(49'h0, "after_reset", p);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
